// File: rtl/job_initiator.sv
// job_initiator: issues a counted burst of start/done jobs to one worker,
// measuring per-job latency, tracking the worst case and aborting on timeout.
`timescale 1ns/1ps
module job_initiator #(
    parameter int unsigned NJ_W       = 8,
    parameter int unsigned LAT_W      = 8,
    parameter int unsigned TIMEOUT    = 200,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             go,
    input  logic [NJ_W-1:0]  num_jobs,
    output logic             start,
    input  logic             done,
    output logic             busy,
    output logic             finished,
    output logic [NJ_W-1:0]  jobs_done,
    output logic [LAT_W-1:0] last_lat,
    output logic [LAT_W-1:0] max_lat,
    output logic             timeout_err
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);
    localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(TIMEOUT);
    localparam logic [NJ_W-1:0]  NJ_MAX    = {NJ_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        GAP    = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [NJ_W-1:0]   remaining;
    logic [LAT_W-1:0]  lat;
    logic [GAP_W-1:0]  gap_cnt;

    logic accept;
    logic complete;
    logic expire;
    logic gap_elapsed;

    // Minimum inter-job gap reached once GAP_CYCLES cycles have been spent in GAP
    always_comb begin
        gap_elapsed = ((32'(gap_cnt) + 32'd1) >= GAP_CYCLES);
    end

    // State register
    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and per-cycle datapath strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    accept     = 1'b1;
                    state_next = (num_jobs != '0) ? ISSUE : FINISH;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (done) begin
                    complete   = 1'b1;
                    state_next = (remaining > NJ_W'(1)) ? GAP : FINISH;
                end else if (lat == LAT_LIMIT) begin
                    expire     = 1'b1;
                    state_next = FINISH;
                end
            end
            GAP: begin
                // A held level-done must drop before the next job is issued
                if (gap_elapsed && !done) state_next = ISSUE;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered handshake/status outputs, aligned with the state register
    always_ff @(posedge clock) begin
        if (rst) begin
            start    <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b0;
        end else begin
            start    <= (state_next == ISSUE);
            busy     <= (state_next != IDLE);
            finished <= (state_next == FINISH);
        end
    end

    // Job bookkeeping: remaining count, latency and gap counters
    always_ff @(posedge clock) begin
        if (rst) begin
            remaining <= '0;
            lat       <= '0;
            gap_cnt   <= '0;
        end else begin
            if (accept) remaining <= num_jobs;
            else if (complete) remaining <= remaining - NJ_W'(1);

            if (state == ISSUE) lat <= LAT_W'(1);
            else if (state == WAIT && !done && !expire) lat <= lat + LAT_W'(1);

            if (complete) gap_cnt <= '0;
            else if (state == GAP && !gap_elapsed) gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

    // Result registers; held in IDLE until the next accepted go
    always_ff @(posedge clock) begin
        if (rst) begin
            jobs_done   <= '0;
            last_lat    <= '0;
            max_lat     <= '0;
            timeout_err <= 1'b0;
        end else if (accept) begin
            jobs_done   <= '0;
            last_lat    <= '0;
            max_lat     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (complete) begin
                last_lat <= lat;
                if (lat > max_lat) max_lat <= lat;
                if (jobs_done != NJ_MAX) jobs_done <= jobs_done + NJ_W'(1);
            end
            if (expire) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_job_initiator.sv
// Directed bench for job_initiator with a behavioural worker (pulse or held done).
`timescale 1ns/1ps
module tb_job_initiator;

    localparam int unsigned NJ_W  = 8;
    localparam int unsigned LAT_W = 8;

    logic             clock = 1'b0;
    logic             rst;
    logic             go;
    logic [NJ_W-1:0]  num_jobs;
    logic             start;
    logic             done;
    logic             busy;
    logic             finished;
    logic [NJ_W-1:0]  jobs_done;
    logic [LAT_W-1:0] last_lat;
    logic [LAT_W-1:0] max_lat;
    logic             timeout_err;

    job_initiator #(
        .NJ_W(NJ_W), .LAT_W(LAT_W), .TIMEOUT(10), .GAP_CYCLES(2)
    ) dut (
        .clock(clock), .rst(rst), .go(go), .num_jobs(num_jobs),
        .start(start), .done(done), .busy(busy), .finished(finished),
        .jobs_done(jobs_done), .last_lat(last_lat), .max_lat(max_lat),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycle counter and start/finished monitor
    int cyc = 0;
    int n_start = 0;
    int n_fin = 0;
    int fin_cyc = 0;
    int st_cyc [0:31];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (start === 1'b1) begin
            if (n_start < 32) st_cyc[n_start] = cyc;
            n_start++;
        end
        if (finished === 1'b1) begin
            n_fin++;
            fin_cyc = cyc;
        end
    end

    // Worker: done rises lats[i] cycles after start i, held hold_len cycles; 0 = never
    int lats [0:15];
    int lat_idx = 0;
    int hold_len = 1;
    int cd = 0;
    int hcnt = 0;

    always @(negedge clock) begin
        if (start === 1'b1) begin
            cd = lats[lat_idx];
            if (lat_idx < 15) lat_idx++;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) hcnt = hold_len;
        end
        if (hcnt > 0) begin
            done = 1'b1;
            hcnt--;
        end else begin
            done = 1'b0;
        end
    end

    task automatic pulse_go(input int n);
        @(negedge clock);
        go = 1'b1;
        num_jobs = NJ_W'(n);
        @(negedge clock);
        go = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("wait_idle", int'(busy), 0);
    endtask

    task automatic set_lats(input int a, input int b, input int c, input int d, input int h);
        for (int i = 0; i < 16; i++) lats[i] = 0;
        lats[0] = a; lats[1] = b; lats[2] = c; lats[3] = d;
        lat_idx = 0;
        hold_len = h;
    endtask

    initial begin
        int b;
        int f;
        int seen;
        rst = 1'b1;
        go = 1'b0;
        num_jobs = '0;
        for (int i = 0; i < 16; i++) lats[i] = 0;
        repeat (3) @(negedge clock);
        check("rst_start", int'(start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_finished", int'(finished), 0);
        check("rst_jobs_done", int'(jobs_done), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        rst = 1'b0;
        @(negedge clock);
        check("post_rst_start", int'(start), 0);
        repeat (2) @(negedge clock);

        // Pulse worker, latency 3, four jobs; a go mid-sequence must be ignored
        set_lats(3, 3, 3, 3, 1);
        b = n_start; f = n_fin;
        pulse_go(4);
        repeat (3) @(negedge clock);
        go = 1'b1; num_jobs = NJ_W'(9);
        @(negedge clock);
        go = 1'b0;
        wait_idle(200);
        check("mealy_starts", n_start - b, 4);
        check("mealy_space01", st_cyc[b+1] - st_cyc[b], 6);
        check("mealy_space23", st_cyc[b+3] - st_cyc[b+2], 6);
        check("mealy_finished", n_fin - f, 1);
        check("mealy_jobs_done", int'(jobs_done), 4);
        check("mealy_last_lat", int'(last_lat), 3);
        check("mealy_max_lat", int'(max_lat), 3);
        check("mealy_timeout_err", int'(timeout_err), 0);
        repeat (4) @(negedge clock);

        // Level worker: done held 4 cycles, latency 2, three jobs
        set_lats(2, 2, 2, 0, 4);
        b = n_start;
        pulse_go(3);
        wait_idle(200);
        repeat (4) @(negedge clock);
        check("moore_starts", n_start - b, 3);
        check("moore_space01", st_cyc[b+1] - st_cyc[b], 7);
        check("moore_space12", st_cyc[b+2] - st_cyc[b+1], 7);
        check("moore_jobs_done", int'(jobs_done), 3);
        check("moore_last_lat", int'(last_lat), 2);

        // Variable latencies 1, 7, 4
        set_lats(1, 7, 4, 0, 1);
        pulse_go(3);
        wait_idle(200);
        check("var_last_lat", int'(last_lat), 4);
        check("var_max_lat", int'(max_lat), 7);
        check("var_jobs_done", int'(jobs_done), 3);
        repeat (4) @(negedge clock);

        // Worker never responds: timeout after 10 cycles of latency
        set_lats(0, 0, 0, 0, 1);
        b = n_start;
        pulse_go(5);
        wait_idle(200);
        check("to_starts", n_start - b, 1);
        check("to_finish_delay", fin_cyc - st_cyc[b], 11);
        check("to_timeout_err", int'(timeout_err), 1);
        check("to_jobs_done", int'(jobs_done), 0);
        check("to_max_lat", int'(max_lat), 0);
        repeat (2) @(negedge clock);
        check("to_err_sticky", int'(timeout_err), 1);

        // Next go clears the error; single latency-1 job
        set_lats(1, 0, 0, 0, 1);
        pulse_go(1);
        check("to_err_cleared", int'(timeout_err), 0);
        wait_idle(200);
        check("lat1_jobs_done", int'(jobs_done), 1);
        check("lat1_last_lat", int'(last_lat), 1);
        repeat (4) @(negedge clock);

        // Zero-job command: no start, single FINISH cycle
        b = n_start; f = n_fin;
        @(negedge clock);
        go = 1'b1; num_jobs = '0;
        @(negedge clock);
        go = 1'b0;
        check("zero_finished", int'(finished), 1);
        check("zero_busy", int'(busy), 1);
        check("zero_jobs_done", int'(jobs_done), 0);
        @(negedge clock);
        check("zero_finished_end", int'(finished), 0);
        check("zero_busy_end", int'(busy), 0);
        repeat (3) @(negedge clock);
        check("zero_starts", n_start - b, 0);
        check("zero_fin_count", n_fin - f, 1);

        // Reset while waiting on job 2; the late done must be ignored
        set_lats(5, 5, 5, 0, 1);
        pulse_go(3);
        seen = 0;
        for (int k = 0; k < 100 && seen < 2; k++) begin
            if (start) seen++;
            if (seen < 2) @(negedge clock);
        end
        check("rst_mid_reached_job2", seen, 2);
        @(negedge clock);
        check("rst_mid_jobs_before", int'(jobs_done), 1);
        check("rst_mid_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clock);
        check("rst_mid_start", int'(start), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_finished", int'(finished), 0);
        check("rst_mid_jobs_done", int'(jobs_done), 0);
        check("rst_mid_last_lat", int'(last_lat), 0);
        check("rst_mid_max_lat", int'(max_lat), 0);
        check("rst_mid_timeout_err", int'(timeout_err), 0);
        rst = 1'b0;
        b = n_start;
        @(negedge clock);
        check("rst_mid_no_start", int'(start), 0);
        repeat (6) @(negedge clock);
        check("late_done_jobs", int'(jobs_done), 0);
        check("late_done_busy", int'(busy), 0);
        check("late_done_last_lat", int'(last_lat), 0);
        check("late_done_starts", n_start - b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
